// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - IF/ID register, field decode, hazard/redirect control and ID/EX register
//
// Purpose:
//   Registers the fetched instruction and pc (IF/ID), decodes it, reads the
//   register file, resolves JMP/BEQ and load-use hazards by redirecting fetch,
//   and presents a registered ID/EX bundle to execute.
//
// Ports:
//   clk                  rising-edge clock shared with fetch
//   reset                asynchronous active-low reset
//   Instr[23:0], pc[7:0] instruction and pc at the current fetch PC
//   PCSrc, immediate     combinational fetch redirect (1 = load immediate)
//   rs1_addr, rs2_addr   combinational register-file read addresses
//   rd1, rd2             asynchronous register-file read data
//   ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_pc   registered ID/EX bundle
//   halted               registered; stage is in HALT
//   illegal              registered, sticky; an opcode 9-15 was decoded

module decode_stage #(
  parameter logic [3:0] NOP_OP = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] Instr,
  input  logic [7:0]  pc,
  output logic        PCSrc,
  output logic [7:0]  immediate,
  output logic [3:0]  rs1_addr,
  output logic [3:0]  rs2_addr,
  input  logic [7:0]  rd1,
  input  logic [7:0]  rd2,
  output logic        ex_valid,
  output logic [3:0]  ex_op,
  output logic [3:0]  ex_rd,
  output logic [7:0]  ex_a,
  output logic [7:0]  ex_b,
  output logic [7:0]  ex_imm,
  output logic [7:0]  ex_pc,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_ADDI  = 4'd3;
  localparam logic [3:0] OP_LOAD  = 4'd4;
  localparam logic [3:0] OP_STORE = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd8;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t      r_state;
  logic        r_ifid_valid;
  logic [23:0] r_ifid_instr;
  logic [7:0]  r_ifid_pc;
  logic [7:0]  r_halt_pc;
  logic        r_halted;
  logic        r_illegal;
  logic        r_ex_valid;
  logic [3:0]  r_ex_op;
  logic [3:0]  r_ex_rd;
  logic [7:0]  r_ex_a;
  logic [7:0]  r_ex_b;
  logic [7:0]  r_ex_imm;
  logic [7:0]  r_ex_pc;

  logic [3:0]  w_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs1;
  logic [3:0]  w_rs2;
  logic [7:0]  w_imm;
  logic [7:0]  w_target;
  logic        w_reads_rs1;
  logic        w_reads_rs2;
  logic        w_load_use;
  logic        w_taken;
  logic        w_in_halt;
  logic        w_issue;
  logic        w_halt_dec;
  logic        w_pcsrc;
  logic [7:0]  w_immediate;

  assign w_op  = r_ifid_instr[23:20];
  assign w_rd  = r_ifid_instr[19:16];
  assign w_rs1 = r_ifid_instr[15:12];
  assign w_rs2 = r_ifid_instr[11:8];
  assign w_imm = r_ifid_instr[7:0];

  // 8-bit add: carry out is dropped so targets wrap modulo 256
  assign w_target = r_ifid_pc + w_imm;

  assign w_reads_rs1 = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_ADDI) ||
                       (w_op == OP_LOAD) || (w_op == OP_STORE) || (w_op == OP_BEQ);
  assign w_reads_rs2 = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                       (w_op == OP_STORE) || (w_op == OP_BEQ);

  assign w_load_use = r_ifid_valid && r_ex_valid && (r_ex_op == OP_LOAD) &&
                      ((w_reads_rs1 && (r_ex_rd == w_rs1)) ||
                       (w_reads_rs2 && (r_ex_rd == w_rs2)));

  assign w_taken = r_ifid_valid &&
                   ((w_op == OP_JMP) || ((w_op == OP_BEQ) && (rd1 == rd2)));

  assign w_in_halt = (r_state == ST_HALT);

  // Only ALU/memory ops occupy execute; control ops and NOP/illegal bubble
  assign w_issue = r_ifid_valid && !w_load_use && !w_in_halt &&
                   ((w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_ADDI) ||
                    (w_op == OP_LOAD) || (w_op == OP_STORE));

  assign w_halt_dec = !w_in_halt && r_ifid_valid && (w_op == OP_HALT) && !w_load_use;

  always_comb begin
    w_pcsrc     = 1'b0;
    w_immediate = 8'h00;
    if (w_in_halt) begin
      w_pcsrc     = 1'b1;
      w_immediate = r_halt_pc;
    end else if (w_load_use) begin
      // replay the stalled instruction once the LOAD has moved on
      w_pcsrc     = 1'b1;
      w_immediate = r_ifid_pc;
    end else if (w_taken) begin
      w_pcsrc     = 1'b1;
      w_immediate = w_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= 24'h0;
      r_ifid_pc    <= 8'h0;
      r_halt_pc    <= 8'h0;
      r_halted     <= 1'b0;
      r_illegal    <= 1'b0;
      r_ex_valid   <= 1'b0;
      r_ex_op      <= 4'h0;
      r_ex_rd      <= 4'h0;
      r_ex_a       <= 8'h0;
      r_ex_b       <= 8'h0;
      r_ex_imm     <= 8'h0;
      r_ex_pc      <= 8'h0;
    end else begin
      // the slot fetched while redirecting is on the wrong path
      r_ifid_valid <= ~w_pcsrc;
      r_ifid_instr <= Instr;
      r_ifid_pc    <= pc;

      case (r_state)
        ST_RUN: begin
          if (w_halt_dec) begin
            r_state   <= ST_HALT;
            r_halted  <= 1'b1;
            r_halt_pc <= r_ifid_pc;
          end
        end
        default: r_state <= ST_HALT;
      endcase

      if (!w_in_halt && r_ifid_valid && (w_op > OP_HALT))
        r_illegal <= 1'b1;

      if (w_issue) begin
        r_ex_valid <= 1'b1;
        r_ex_op    <= w_op;
        r_ex_rd    <= w_rd;
        r_ex_a     <= rd1;
        r_ex_b     <= rd2;
        r_ex_imm   <= w_imm;
        r_ex_pc    <= r_ifid_pc;
      end else begin
        r_ex_valid <= 1'b0;
        r_ex_op    <= NOP_OP;
        r_ex_rd    <= 4'h0;
        r_ex_a     <= 8'h0;
        r_ex_b     <= 8'h0;
        r_ex_imm   <= 8'h0;
        r_ex_pc    <= 8'h0;
      end
    end
  end

  assign PCSrc     = w_pcsrc;
  assign immediate = w_immediate;
  assign rs1_addr  = w_rs1;
  assign rs2_addr  = w_rs2;
  assign ex_valid  = r_ex_valid;
  assign ex_op     = r_ex_op;
  assign ex_rd     = r_ex_rd;
  assign ex_a      = r_ex_a;
  assign ex_b      = r_ex_b;
  assign ex_imm    = r_ex_imm;
  assign ex_pc     = r_ex_pc;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage

module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [23:0] instr;
  logic [7:0]  f_pc;
  logic        pcsrc;
  logic [7:0]  immediate;
  logic [3:0]  rs1_addr, rs2_addr;
  logic [7:0]  rd1, rd2;
  logic        ex_valid;
  logic [3:0]  ex_op, ex_rd;
  logic [7:0]  ex_a, ex_b, ex_imm, ex_pc;
  logic        halted, illegal;

  logic [23:0] imem [256];
  logic [7:0]  regs [16];

  int n_checks = 0;
  int n_errors = 0;

  decode_stage #(.NOP_OP(4'h0)) dut (
    .clk(clk), .reset(rst_n), .Instr(instr), .pc(f_pc),
    .PCSrc(pcsrc), .immediate(immediate),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd1(rd1), .rd2(rd2),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .halted(halted), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // fetch model: pc resets to 0, increments, or loads the redirect target
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_pc <= 8'h00;
    else        f_pc <= pcsrc ? immediate : f_pc + 8'h01;
  end

  assign instr = imem[f_pc];
  assign rd1   = regs[rs1_addr];
  assign rd2   = regs[rs2_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // hold reset, clear memory, default register file contents
  task automatic begin_test();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 24'h0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h10 + 8'(i);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;

    // sequential ADD / SUB
    begin_test();
    imem[0] = 24'h112300;  // ADD rd1 rs2 rs3
    imem[1] = 24'h245600;  // SUB rd4 rs5 rs6
    check("rst_ex", {ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_pc}, 0);
    check("rst_ctl", {pcsrc, immediate, halted, illegal}, 0);
    release_reset();
    edges(1);
    check("s1_pcsrc0", pcsrc, 0);
    check("s1_rs1", rs1_addr, 4'h2);
    edges(1);
    check("s1_add", {ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_pc}, {1'b1, 4'h1, 4'h1, 8'h12, 8'h13, 8'h00});
    check("s1_pcsrc1", pcsrc, 0);
    edges(1);
    check("s1_sub", {ex_valid, ex_op, ex_rd, ex_a, ex_pc}, {1'b1, 4'h2, 4'h4, 8'h15, 8'h01});

    // JMP at pc 2, imm 5 -> 7
    begin_test();
    imem[2] = 24'h700005;
    imem[3] = 24'h112300;  // wrong path
    imem[7] = 24'h312009;  // ADDI imm 9
    release_reset();
    edges(3);
    check("jmp_redir", {pcsrc, immediate}, {1'b1, 8'h07});
    edges(1);
    check("jmp_bub1", ex_valid, 0);
    edges(1);
    check("jmp_squash", ex_valid, 0);
    edges(1);
    check("jmp_tgt", {ex_valid, ex_op, ex_imm, ex_pc}, {1'b1, 4'h3, 8'h09, 8'h07});

    // BEQ taken at pc 3, imm 4 -> 7
    begin_test();
    imem[3] = 24'h601204;
    regs[1] = 8'h2A; regs[2] = 8'h2A;
    release_reset();
    edges(4);
    check("beq_taken", {pcsrc, immediate}, {1'b1, 8'h07});

    // BEQ not taken, following ADD flows
    begin_test();
    imem[3] = 24'h601204;
    imem[4] = 24'h112300;
    regs[1] = 8'h2A; regs[2] = 8'h2B;
    release_reset();
    edges(4);
    check("beq_nt", {pcsrc, immediate}, 0);
    edges(2);
    check("beq_nt_next", {ex_valid, ex_op, ex_pc}, {1'b1, 4'h1, 8'h04});

    // load-use: LOAD rd3 at pc4, ADD rs1=3 at pc5
    begin_test();
    imem[4] = 24'h430000;
    imem[5] = 24'h153000;
    release_reset();
    edges(6);
    check("lu_load", {ex_valid, ex_op, ex_rd}, {1'b1, 4'h4, 4'h3});
    check("lu_replay", {pcsrc, immediate}, {1'b1, 8'h05});
    edges(1);
    check("lu_bub1", {ex_valid, pcsrc}, 0);
    edges(1);
    check("lu_bub2", ex_valid, 0);
    edges(1);
    check("lu_add", {ex_valid, ex_op, ex_rd, ex_pc}, {1'b1, 4'h1, 4'h5, 8'h05});

    // HALT at pc 6
    begin_test();
    imem[6] = 24'h800000;
    imem[7] = 24'h112300;
    release_reset();
    edges(7);
    check("halt_dec", {halted, pcsrc}, 0);
    edges(1);
    check("halt_up", halted, 1);
    for (int i = 0; i < 12; i++) begin
      check("halt_hold", {pcsrc, immediate, ex_valid}, {1'b1, 8'h06, 1'b0});
      edges(1);
    end
    #2 rst_n = 1'b0;
    #1 check("halt_async_rst", {halted, pcsrc, immediate}, 0);

    // illegal opcode, then JMP at 0xFE wrapping to 0x03
    begin_test();
    imem[0]     = 24'hB00000;
    imem[1]     = 24'h7000FD;  // 1 + 0xFD = 0xFE
    imem[8'hFE] = 24'h700005;
    release_reset();
    edges(1);
    check("ill_pre", illegal, 0);
    edges(1);
    check("ill_set", {illegal, ex_valid}, {1'b1, 1'b0});
    check("jmp_fe", {pcsrc, immediate}, {1'b1, 8'hFE});
    edges(2);
    check("jmp_wrap", {pcsrc, immediate, illegal}, {1'b1, 8'h03, 1'b1});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage directly downstream of the instruction-memory/PC fetch block. It registers the fetched 24-bit `Instr` and its `pc` (IF/ID), decodes fields and reads the register file. It resolves JMP/BEQ and load-use hazards by driving `PCSrc`/`immediate` back into fetch, and presents a registered ID/EX bundle to the execute stage.

## Interface
- `NOP_OP`, default 4'h0, opcode injected into ID/EX on a bubble.
- `clk`  in  1  rising-edge clock shared with fetch.
- `reset`  in  1  asynchronous, active-low reset.
- `Instr`  in  24  instruction at current fetch PC.
- `pc`  in  8  current fetch PC.
- `PCSrc`  out  1  combinational; 1 = fetch loads `immediate` as next PC at this edge.
- `immediate`  out  8  combinational redirect target.
- `rs1_addr`, `rs2_addr`  out  4 each  combinational register-file read addresses.
- `rd1`, `rd2`  in  8 each  register-file read data (asynchronous read).
- `ex_valid`  out  1  ID/EX holds a real instruction.
- `ex_op`, `ex_rd`  out  4 each  registered opcode and destination.
- `ex_a`, `ex_b`, `ex_imm`, `ex_pc`  out  8 each  registered operands, imm8, and instruction PC.
- `halted`  out  1  registered; stage is in HALT.
- `illegal`  out  1  registered, sticky; an opcode 9–15 was decoded.

## Operation
- Format: [23:20] op, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] imm8.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 ADDI, 4 LOAD, 5 STORE, 6 BEQ, 7 JMP, 8 HALT, 9–15 illegal (executed as NOP, sets `illegal`).
- IF/ID register: {valid, instr, pc}. Every edge it captures `Instr`/`pc`. valid <= ~redirect, where redirect = `PCSrc`.
- `rs1_addr`/`rs2_addr` = IF/ID rs1/rs2 regardless of valid.
- Branch target = IF/ID pc + imm8, mod 256 (carry discarded).
- Taken: valid JMP, or valid BEQ with `rd1 == rd2`.
- Load-use hazard: `ex_valid` and `ex_op` == LOAD and `ex_rd` matches a source that the decode instruction reads. rs1 is read by ADD, SUB, ADDI, LOAD, STORE, BEQ. rs2 is read by ADD, SUB, STORE, BEQ.
- FSM states RUN and HALT. RUN -> HALT when a valid HALT is in IF/ID with no hazard. HALT exits only via reset.
- Redirect priority, highest first:
  - HALT state: `PCSrc`=1, `immediate` = latched halt pc.
  - Load-use: `PCSrc`=1, `immediate` = IF/ID pc (replay).
  - Taken branch: `PCSrc`=1, `immediate` = target.
  - Otherwise `PCSrc`=0, `immediate`=0.
- ID/EX update each edge:
  - Bubble (ex_valid=0, ex_op=`NOP_OP`, other fields 0) when IF/ID invalid, load-use, HALT state, or decoding HALT/JMP/BEQ/NOP/illegal.
  - Otherwise load op, rd, rd1, rd2, imm8, pc with ex_valid=1.

## Timing
- Reset asserted (low) clears immediately: IF/ID valid=0, all ID/EX outputs 0, `halted`=0, `illegal`=0, FSM=RUN. Consequently `PCSrc`=0 and `immediate`=0.
- First edge after release captures instruction at pc 0 (fetch resets to 0).
- Decode latency: 1 cycle, IF/ID to ID/EX.
- Taken JMP/BEQ costs one bubble. The wrong-path instruction captured at the redirect edge enters IF/ID with valid=0.
- Load-use costs 2 bubbles: the replay cycle plus the squashed slot. The replayed instruction re-decodes once the LOAD has left ID/EX.
- HALT: `halted` rises at the edge after HALT decodes. Fetch is redirected to the HALT pc every cycle, and all IF/ID captures are squashed.
- Reset mid-operation aborts all in-flight state asynchronously, with no partial ID/EX update.
- Simultaneous load-use and taken BEQ in the same cycle: load-use wins. The branch re-evaluates after replay with forwarded-safe data.
- Branch target wrap: pc 0xFE + imm8 0x05 gives 0x03.

## Test plan
- Reset then sequential ADD at pc 0, SUB at pc 1 -> `PCSrc`=0 throughout. ID/EX shows ADD `ex_pc`=0 at the 2nd edge and SUB `ex_pc`=1 at the 3rd. All outputs are 0 while reset is low.
- JMP imm8=0x05 at pc 2 -> during decode `PCSrc`=1, `immediate`=0x07. The next cycle `ex_valid`=0, and the following IF/ID instruction has pc 0x07.
- BEQ at pc 3, imm8=0x04: with rd1=rd2=0x2A -> redirect to 0x07. With rd1=0x2A, rd2=0x2B -> `PCSrc`=0 and no bubble.
- LOAD rd=3 at pc 4, then ADD rs1=3 at pc 5 -> `PCSrc`=1, `immediate`=0x05 for one cycle. Two bubbles follow, then ADD reaches ID/EX with `ex_pc`=5.
- HALT at pc 6 -> `halted`=1 at the next edge. `PCSrc`=1 and `immediate`=0x06 hold for 10+ cycles, and `ex_valid` stays 0. Pulling reset low mid-halt clears `halted` asynchronously.
- Opcode 0xB at pc 0, then JMP at pc 0xFE imm8=0x05 -> `illegal`=1 sticky with a bubble in ID/EX. The JMP target is 0x03.
